// File: rtl/add_share_arbiter_pkg.sv
// Shared constants, helpers and stage typedef for the shared-adder arbiter.
// Used by add_share_arbiter and by other shared units in the arithmetic cluster.
package add_arb_pkg;

  localparam int CNT_W    = 16;
  localparam int DATA_W   = 8;
  localparam int ID_MAX_W = 4;

  // Requester index width; never narrower than one bit.
  function automatic int id_w(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  typedef struct packed {
    logic                      valid;
    logic [ID_MAX_W-1:0]       id;
    logic signed [DATA_W-1:0]  a;
    logic signed [DATA_W-1:0]  b;
  } arb_stage_t;

endpackage

// File: rtl/add_share_arbiter_if.sv
// Request/response bundle between lane request logic (master) and the
// shared adder (slave).
interface add_share_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8
);
  import add_arb_pkg::*;

  localparam int ID_W = id_w(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0][WIDTH-1:0] req_a;
  logic [NUM_REQ-1:0][WIDTH-1:0] req_b;
  logic                          rsp_valid;
  logic                          rsp_ready;
  logic [WIDTH:0]                rsp_sum;
  logic [ID_W-1:0]               rsp_id;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_sum, rsp_id
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_sum, rsp_id
  );

endinterface

// File: rtl/add_share_arbiter_rr_arbiter.sv
// Round-robin one-hot arbiter: search starts just after 'last' and wraps.
// Reusable by any shared unit in the cluster.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant
);

  logic [ID_W:0]           sh;
  logic [2*NUM_REQ-1:0]    req_dbl;
  logic [2*NUM_REQ-1:0]    gnt_dbl;
  logic [NUM_REQ-1:0]      rot_req;
  logic [NUM_REQ-1:0]      rot_gnt;

  // Rotate so index last+1 sits at bit 0, pick lowest set bit, rotate back.
  assign sh      = {1'b0, last} + (ID_W + 1)'(1);
  assign req_dbl = {req, req};
  assign rot_req = NUM_REQ'(req_dbl >> sh);
  assign rot_gnt = rot_req & (~rot_req + NUM_REQ'(1));
  assign gnt_dbl = {rot_gnt, rot_gnt} << sh;
  assign grant   = en ? gnt_dbl[2*NUM_REQ-1:NUM_REQ] : '0;

endmodule

// File: rtl/add_share_arbiter.sv
// One registered signed adder shared round-robin by NUM_REQ requesters, 2-stage pipe.
// Optional per-requester grant counters on the grant_cnt port with ADD_ARB_STATS_EN.
module add_share_arbiter
  import add_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  add_share_arbiter_if.slave            bus
`ifdef ADD_ARB_STATS_EN
  ,
  output logic [NUM_REQ-1:0][CNT_W-1:0] grant_cnt
`endif
);

  localparam int ID_W = id_w(NUM_REQ);

  logic                s1_v_reg;
  logic [WIDTH-1:0]    s1_a_reg;
  logic [WIDTH-1:0]    s1_b_reg;
  logic [ID_W-1:0]     s1_id_reg;
  logic                s2_v_reg;
  logic [WIDTH:0]      s2_sum_reg;
  logic [ID_W-1:0]     s2_id_reg;
  logic [ID_W-1:0]     last_reg;

  logic                s1_free;
  logic                s2_free;
  logic [NUM_REQ-1:0]  grant;
  logic                xfer;
  logic [ID_W-1:0]     grant_id;
  logic [WIDTH-1:0]    sel_a;
  logic [WIDTH-1:0]    sel_b;
  logic [WIDTH:0]      sum_next;

  assign s2_free = !s2_v_reg || bus.rsp_ready;
  assign s1_free = !s1_v_reg || s2_free;

  // Gating the enable with rst_n keeps req_ready low for the whole reset.
  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .req   (bus.req_valid),
    .last  (last_reg),
    .en    (s1_free && rst_n),
    .grant (grant)
  );

  assign bus.req_ready = grant;
  assign xfer          = |grant;

  always_comb begin
    grant_id = '0;
    sel_a    = '0;
    sel_b    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        grant_id = ID_W'(i);
        sel_a    = bus.req_a[i];
        sel_b    = bus.req_b[i];
      end
    end
  end

  assign sum_next = {s1_a_reg[WIDTH-1], s1_a_reg} + {s1_b_reg[WIDTH-1], s1_b_reg};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_reg  <= ID_W'(NUM_REQ - 1);
      s1_v_reg  <= 1'b0;
      s1_a_reg  <= '0;
      s1_b_reg  <= '0;
      s1_id_reg <= '0;
    end else begin
      if (xfer) begin
        last_reg <= grant_id;
      end
      if (s1_free) begin
        s1_v_reg <= xfer;
        if (xfer) begin
          s1_a_reg  <= sel_a;
          s1_b_reg  <= sel_b;
          s1_id_reg <= grant_id;
        end
      end
    end
  end

  // S2 registers only load on an advance, so results hold while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v_reg   <= 1'b0;
      s2_sum_reg <= '0;
      s2_id_reg  <= '0;
    end else if (s2_free) begin
      s2_v_reg <= s1_v_reg;
      if (s1_v_reg) begin
        s2_sum_reg <= sum_next;
        s2_id_reg  <= s1_id_reg;
      end
    end
  end

  assign bus.rsp_valid = s2_v_reg;
  assign bus.rsp_sum   = s2_sum_reg;
  assign bus.rsp_id    = s2_id_reg;

`ifdef ADD_ARB_STATS_EN
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg <= '0;
        end else if (grant[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end

      assign grant_cnt[gi] = cnt_reg;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_add_share_arbiter.sv
// Randomized bench for add_share_arbiter against a queue-based transaction model.
// Stats scenario runs only when ADD_ARB_STATS_EN is defined.
module tb_add_share_arbiter;
  import add_arb_pkg::*;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int IDW = id_w(N);

  typedef struct {
    int sum;
    int id;
    int t;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  add_share_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus ();

`ifdef ADD_ARB_STATS_EN
  logic [N-1:0][CNT_W-1:0] grant_cnt;
`endif

  add_share_arbiter #(
    .NUM_REQ (N),
    .WIDTH   (W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef ADD_ARB_STATS_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  exp_t           q[$];
  int             grant_log[$];
  int             n_vec    = 0;
  int             n_err    = 0;
  int             edge_cnt = 0;
  int             m_last   = N - 1;
  int             m_cnt[N];
  int             acc_cnt  = 0;
  int             drained  = 0;
  int             gen_rate = 0;
  int             rdy_rate = 100;
  logic [N-1:0]   gen_mask = '0;
  bit             verbose  = 1'b0;

  function automatic logic [W-1:0] rand_op();
    case ($urandom_range(7))
      0:       return 8'h80;
      1:       return 8'h7F;
      default: return W'($urandom);
    endcase
  endfunction

  // One clock of the reference model: check at negedge, then drive after posedge.
  task automatic tick();
    int           size;
    bit           s2_occ;
    bit           s1_occ;
    bit           s1_free;
    int           idx;
    logic [N-1:0] exp_g;
    logic [N-1:0] accepted;
    exp_t         e;
    @(negedge clk);
    accepted = '0;
    if (!rst_n) begin
      n_vec++;
      if (bus.req_ready !== '0 || bus.rsp_valid !== 1'b0 ||
          bus.rsp_sum !== '0 || bus.rsp_id !== '0) begin
        n_err++;
        $display("FAIL reset_hold: req_ready=%b rsp_valid=%b sum=%h id=%0d, required 0", bus.req_ready, bus.rsp_valid, bus.rsp_sum, bus.rsp_id);
      end
      q.delete();
      m_last = N - 1;
    end else begin
      size    = q.size();
      s2_occ  = (size > 0) && (q[0].t + 1 <= edge_cnt);
      s1_occ  = (size - int'(s2_occ)) > 0;
      s1_free = !s1_occ || !s2_occ || bus.rsp_ready;
      n_vec++;
      if (bus.rsp_valid !== s2_occ) begin
        n_err++;
        $display("FAIL rsp_valid: got %b, required %b (edge %0d)", bus.rsp_valid, s2_occ, edge_cnt);
      end
      if (s2_occ) begin
        n_vec++;
        if (bus.rsp_sum !== (W + 1)'(q[0].sum) || bus.rsp_id !== IDW'(q[0].id)) begin
          n_err++;
          $display("FAIL rsp_data: got sum=%h id=%0d, required sum=%h id=%0d", bus.rsp_sum, bus.rsp_id, (W + 1)'(q[0].sum), q[0].id);
        end
      end
      exp_g = '0;
      if (s1_free) begin
        for (int k = 1; k <= N; k++) begin
          idx = (m_last + k) % N;
          if (bus.req_valid[idx]) begin
            exp_g[idx] = 1'b1;
            break;
          end
        end
      end
      n_vec++;
      if (bus.req_ready !== exp_g) begin
        n_err++;
        $display("FAIL req_ready: got %b, required %b (edge %0d)", bus.req_ready, exp_g, edge_cnt);
      end
      for (int i = 0; i < N; i++) begin
        if (exp_g[i]) begin
          e.sum = int'($signed(bus.req_a[i])) + int'($signed(bus.req_b[i]));
          e.id  = i;
          e.t   = edge_cnt + 1;
          q.push_back(e);
          m_last = i;
          grant_log.push_back(i);
          acc_cnt++;
          if (m_cnt[i] < 65535) m_cnt[i]++;
        end
      end
      if (s2_occ && bus.rsp_ready) begin
        if (verbose) $display("rsp id=%0d sum=%0d", q[0].id, q[0].sum);
        void'(q.pop_front());
        drained++;
      end
      accepted = bus.req_ready;
    end
    @(posedge clk);
    edge_cnt++;
    #1;
    for (int i = 0; i < N; i++) begin
      if (accepted[i] || !bus.req_valid[i]) begin
        if (gen_mask[i] && ($urandom_range(99) < gen_rate)) begin
          bus.req_valid[i] = 1'b1;
          bus.req_a[i]     = rand_op();
          bus.req_b[i]     = rand_op();
        end else begin
          bus.req_valid[i] = 1'b0;
        end
      end
    end
    bus.rsp_ready = ($urandom_range(99) < rdy_rate);
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    gen_rate      = 0;
    gen_mask      = '0;
    rdy_rate      = 100;
    tick();
    tick();
    rst_n = 1'b1;
    q.delete();
    grant_log.delete();
    m_last = N - 1;
    foreach (m_cnt[i]) m_cnt[i] = 0;
  endtask

  task automatic fill_all();
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i] = 1'b1;
      bus.req_a[i]     = rand_op();
      bus.req_b[i]     = rand_op();
    end
  endtask

  task automatic test_reset();
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_valid = '1;
    bus.rsp_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    tick();
    tick();
    n_vec++;
    if (bus.req_ready !== '0 || bus.rsp_valid !== 1'b0 || bus.rsp_sum !== '0 || bus.rsp_id !== '0) begin
      n_err++;
      $display("FAIL test_reset: ready=%b valid=%b sum=%h id=%0d, required all 0", bus.req_ready, bus.rsp_valid, bus.rsp_sum, bus.rsp_id);
    end
    bus.req_valid = '0;
    rst_n = 1'b1;
    q.delete();
    m_last = N - 1;
    foreach (m_cnt[i]) m_cnt[i] = 0;
  endtask

  task automatic test_single();
    do_reset();
    verbose      = 1'b1;
    bus.req_a[2] = 8'sd100;
    bus.req_b[2] = 8'sd27;
    bus.req_valid = 4'b0100;
    #1;
    n_vec++;
    if (bus.req_ready !== 4'b0100) begin
      n_err++;
      $display("FAIL single_ready: got %b, required 0100", bus.req_ready);
    end
    tick();
    tick();
    n_vec++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_sum !== 9'sd127 || bus.rsp_id !== 2'd2) begin
      n_err++;
      $display("FAIL single_rsp: got valid=%b sum=%0d id=%0d, required 1/127/2", bus.rsp_valid, bus.rsp_sum, bus.rsp_id);
    end
    repeat (2) tick();
    verbose = 1'b0;
  endtask

  task automatic test_contention();
    do_reset();
    gen_mask = '1;
    gen_rate = 100;
    fill_all();
    repeat (8) tick();
    n_vec++;
    if (grant_log.size() < 8) begin
      n_err++;
      $display("FAIL contention_count: got %0d grants, required 8", grant_log.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_vec++;
        if (grant_log[i] != i % N) begin
          n_err++;
          $display("FAIL contention_order[%0d]: got %0d, required %0d", i, grant_log[i], i % N);
        end
      end
    end
    gen_rate = 0;
    repeat (8) tick();
  endtask

  task automatic test_extremes();
    do_reset();
    verbose       = 1'b1;
    bus.req_a[0]  = 8'h80;
    bus.req_b[0]  = 8'h80;
    bus.req_valid = 4'b0001;
    tick();
    bus.req_a[0]  = 8'h7F;
    bus.req_b[0]  = 8'h7F;
    bus.req_valid = 4'b0001;
    tick();
    n_vec++;
    if (bus.rsp_sum !== 9'h100) begin
      n_err++;
      $display("FAIL extreme_neg: got %h, required 100", bus.rsp_sum);
    end
    tick();
    n_vec++;
    if (bus.rsp_sum !== 9'h0FE) begin
      n_err++;
      $display("FAIL extreme_pos: got %h, required 0fe", bus.rsp_sum);
    end
    repeat (2) tick();
    verbose = 1'b0;
  endtask

  task automatic test_back_pressure();
    int exp0;
    do_reset();
    rdy_rate      = 0;
    bus.rsp_ready = 1'b0;
    gen_mask      = '1;
    gen_rate      = 100;
    fill_all();
    exp0    = int'($signed(bus.req_a[0])) + int'($signed(bus.req_b[0]));
    acc_cnt = 0;
    drained = 0;
    repeat (5) tick();
    n_vec++;
    if (acc_cnt != 2 || bus.req_ready !== '0) begin
      n_err++;
      $display("FAIL bp_capture: got %0d accepts ready=%b, required 2 and 0000", acc_cnt, bus.req_ready);
    end
    n_vec++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0 || bus.rsp_sum !== (W + 1)'(exp0)) begin
      n_err++;
      $display("FAIL bp_hold: got valid=%b id=%0d sum=%h, required 1/0/%h", bus.rsp_valid, bus.rsp_id, bus.rsp_sum, (W + 1)'(exp0));
    end
    rdy_rate      = 100;
    bus.rsp_ready = 1'b1;
    gen_rate      = 0;
    repeat (12) tick();
    n_vec++;
    if (q.size() != 0 || drained != acc_cnt) begin
      n_err++;
      $display("FAIL bp_drain: got %0d drained of %0d, %0d left, required all", drained, acc_cnt, q.size());
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    rdy_rate      = 0;
    bus.rsp_ready = 1'b0;
    gen_mask      = '1;
    gen_rate      = 100;
    fill_all();
    repeat (3) tick();
    n_vec++;
    if (bus.rsp_valid !== 1'b1) begin
      n_err++;
      $display("FAIL midflight_pre: got rsp_valid=%b, required 1", bus.rsp_valid);
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_sum !== '0 || bus.req_ready !== '0) begin
      n_err++;
      $display("FAIL midflight_async: got valid=%b sum=%h ready=%b, required 0", bus.rsp_valid, bus.rsp_sum, bus.req_ready);
    end
    q.delete();
    grant_log.delete();
    m_last = N - 1;
    foreach (m_cnt[i]) m_cnt[i] = 0;
    rdy_rate      = 100;
    bus.rsp_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    n_vec++;
    if (grant_log.size() == 0 || grant_log[0] != 0) begin
      n_err++;
      $display("FAIL midflight_first_grant: got %0d, required 0", (grant_log.size() == 0) ? -1 : grant_log[0]);
    end
    gen_rate = 0;
    repeat (8) tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int blk = 0; blk < 15; blk++) begin
      gen_rate = $urandom_range(100, 10);
      rdy_rate = $urandom_range(100, 20);
      gen_mask = N'($urandom);
      repeat (100) tick();
    end
    gen_rate = 0;
    rdy_rate = 100;
    repeat (12) tick();
    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL random_drain: got %0d outstanding, required 0", q.size());
    end
  endtask

`ifdef ADD_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    for (int i = 0; i < N; i++) begin
      n_vec++;
      if (grant_cnt[i] !== '0) begin
        n_err++;
        $display("FAIL stats_reset[%0d]: got %h, required 0", i, grant_cnt[i]);
      end
    end
    gen_mask         = 4'b0010;
    gen_rate         = 100;
    bus.req_valid[1] = 1'b1;
    bus.req_a[1]     = rand_op();
    bus.req_b[1]     = rand_op();
    repeat (70000) tick();
    gen_rate = 0;
    repeat (4) tick();
    for (int i = 0; i < N; i++) begin
      n_vec++;
      if (grant_cnt[i] !== CNT_W'(m_cnt[i]) || (i == 1 && grant_cnt[i] !== 16'hFFFF)) begin
        n_err++;
        $display("FAIL stats_count[%0d]: got %h, required %h", i, grant_cnt[i], CNT_W'(m_cnt[i]));
      end
    end
  endtask
`endif

  initial begin
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;
    foreach (m_cnt[i]) m_cnt[i] = 0;
    test_reset();
    test_single();
    test_contention();
    test_extremes();
    test_back_pressure();
    test_reset_midflight();
    test_random();
`ifdef ADD_ARB_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/add_share_arbiter.md
# add_share_arbiter

Shares a single registered signed adder among `NUM_REQ` requesters, each of which would otherwise instantiate its own adder. The block arbitrates round-robin, accepts one operand pair per cycle and pushes it through a two-stage pipeline. It returns each sum tagged with the requester index. It sits between the per-lane request logic and the lane result collectors in the arithmetic cluster.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters; legal range 2..16.
- `WIDTH`, 8: operand width in bits; operands are signed two's-complement.

Ports:
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in `NUM_REQ`: per-requester operand pair valid.
- `req_ready` out `NUM_REQ`: per-requester accept; one-hot or zero.
- `req_a` in `NUM_REQ`×`WIDTH`: per-requester operand A, signed.
- `req_b` in `NUM_REQ`×`WIDTH`: per-requester operand B, signed.
- `rsp_valid` out 1: result valid.
- `rsp_ready` in 1: consumer accepts the result.
- `rsp_sum` out `WIDTH`+1: signed sum `a+b`, full precision, never overflows.
- `rsp_id` out `ID_W`: index of the requester that owns `rsp_sum`.
- `grant_cnt` out `NUM_REQ`×16: present only with `ADD_ARB_STATS_EN`; per-requester count of accepted transfers.

## Operation
- **Arbitration:** round-robin over requesters asserting `req_valid`.
  - The pointer `last` holds the most recently granted index.
  - Search starts at `last+1` and wraps from `NUM_REQ-1` to 0.
  - The grant is combinational from `req_valid`, `last` and `s1_free`.
  - `req_ready[i]` = grant[i] & `s1_free`.
  - `last` updates only on an actual transfer (valid & ready).
- **Stage 1 (S1):** registers `a`, `b` and `id` of the granted requester, plus `s1_v`.
  - `s1_free` = !`s1_v` | `s2_free`.
- **Stage 2 (S2):** registers `sum = sext(a) + sext(b)` to `WIDTH`+1 bits, plus `id` and `s2_v`.
  - `s2_free` = !`s2_v` | `rsp_ready`.
- **Outputs:** `rsp_valid` = `s2_v`. `rsp_sum` and `rsp_id` come straight from S2 registers.
- **Back-pressure:** stages advance only when the stage downstream is free. With `rsp_ready` low, S2 and then S1 hold and `req_ready` goes all-zero. No data is dropped or duplicated.
- **Handshake rules:**
  - A requester may not withdraw `req_valid` or change its operands until it sees `req_ready`.
  - `rsp_sum` and `rsp_id` stay stable while `rsp_valid` & !`rsp_ready`.
- **Simultaneous events:** S2 drain and S1→S2 advance in the same cycle are legal and sustain throughput of 1 result per cycle.
- **Reset values:**
  - `s1_v` = `s2_v` = 0, so `rsp_valid` = 0.
  - `rsp_sum` = 0, `rsp_id` = 0.
  - `last` = `NUM_REQ-1`, so requester 0 wins first.
  - `req_ready` = 0 while `rst_n` is low.
  - `grant_cnt` = 0.
- **Reset mid-operation:** in-flight results are discarded immediately. The first post-reset grant goes to index 0.

## Timing
- Latency is 2 cycles: a transfer at edge N gives `rsp_valid` high after edge N+1 and consumable at edge N+2.
- Throughput is 1 transfer per cycle when `rsp_ready` is held high.
- Under full contention, each requester is served within `NUM_REQ` accepted transfers (no starvation).
- `req_ready` is combinational from `req_valid` and `rsp_ready`. There is no combinational path from `req_a`/`req_b` to any output.

## Configuration
- **Macro:** `ADD_ARB_STATS_EN`.
- **Defined:** `grant_cnt` exists.
  - Each 16-bit counter increments on its requester's transfer.
  - Counters saturate at 16'hFFFF and reset to 0.
- **Undefined:** the port and counters are absent. Arbitration and datapath behaviour are identical.

## Structure
- **Package `add_arb_pkg`:**
  - `ID_W = $clog2(NUM_REQ)` helper function.
  - `CNT_W = 16`.
  - Typedef `arb_stage_t` struct {valid, id, a, b}, parameterised by width via the package's width constant.
- **Sub-module `rr_arbiter`:** inputs are request vector, `last` and enable; output is one-hot grant. It is reusable by other shared units in the cluster.

## Test plan
- **Single request, idle pipe:** `req_valid[2]`=1, a=8'sd100, b=8'sd27 → `req_ready[2]`=1 that cycle; 2 cycles later `rsp_sum`=9'sd127, `rsp_id`=2.
- **Full contention** (all 4 valid, `rsp_ready`=1, 8 transfers) → grant order 0,1,2,3,0,1,2,3; `rsp_id` follows the same order 2 cycles later.
- **Width extremes:**
  - a=-128, b=-128 → `rsp_sum`=-256 (9'h100).
  - a=127, b=127 → 254 (9'h0FE).
- **Back-pressure:** hold `rsp_ready`=0 for 5 cycles with requests pending.
  - Expect 2 entries captured, then `req_ready`=0 and `rsp_sum`/`rsp_id` stable.
  - On release, results drain in order with none lost.
- **Reset mid-flight:** drop `rst_n` with S1 and S2 both valid → `rsp_valid`=0 asynchronously; after release the next grant goes to requester 0.
- **With `ADD_ARB_STATS_EN`:** 70000 transfers from requester 1 → `grant_cnt[1]`=16'hFFFF, other counters 0.
